// File: rtl/cart_mem_arbiter.sv
// Single-port arbiter/sequencer for the external cartridge memory.
// Priority: cartridge slot, then refresh, then image loader; one command in flight.
module cart_mem_arbiter #(
  parameter int unsigned REFRESH_CYCLES = 780
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cart_req,
  input  logic        cart_wr,
  input  logic [22:0] cart_addr,
  input  logic [7:0]  cart_wdata,
  output logic [7:0]  cart_rdata,
  output logic        cart_ack,
  input  logic        ld_req,
  input  logic        ld_wr,
  input  logic [22:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  output logic [7:0]  ld_rdata,
  output logic        ld_ack,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wr,
  output logic        mem_ref,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic        ref_overrun,
  output logic        cart_overrun
);

  localparam int unsigned CW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_RD} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_CART, SRC_REF, SRC_LD} src_t;

  state_t state_q, state_d;
  src_t   src_q, src_d;

  logic          slot_valid_q;
  logic          slot_wr_q;
  logic [22:0]   slot_addr_q;
  logic [7:0]    slot_wdata_q;
  logic [CW-1:0] ref_cnt_q;
  logic          ref_pending_q;

  logic        grant_cart, grant_ref, grant_ld;
  logic        accept, rd_done;
  logic        cart_avail, ld_avail;
  logic        sel_wr;
  logic [22:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic        slot_free_now, ref_clear, ref_expire;

  // The slot covers the in-flight cart command too; a direct grant also occupies it.
  assign cart_avail    = slot_valid_q | cart_req;
  // ld_req is still high in the ack cycle; only count it again from the next cycle.
  assign ld_avail      = ld_req & ~ld_ack;
  assign accept        = (state_q == CMD) & mem_ready;
  assign slot_free_now = accept & (src_q == SRC_CART);
  assign ref_clear     = accept & (src_q == SRC_REF);
  assign ref_expire    = (ref_cnt_q == '0);
  assign sel_wr        = slot_valid_q ? slot_wr_q    : cart_wr;
  assign sel_addr      = slot_valid_q ? slot_addr_q  : cart_addr;
  assign sel_wdata     = slot_valid_q ? slot_wdata_q : cart_wdata;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    grant_cart = 1'b0;
    grant_ref  = 1'b0;
    grant_ld   = 1'b0;
    rd_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cart_avail) begin
          grant_cart = 1'b1;
          src_d      = SRC_CART;
          state_d    = CMD;
        end else if (ref_pending_q) begin
          grant_ref = 1'b1;
          src_d     = SRC_REF;
          state_d   = CMD;
        end else if (ld_avail) begin
          grant_ld = 1'b1;
          src_d    = SRC_LD;
          state_d  = CMD;
        end
      end
      CMD: begin
        if (mem_ready) begin
          state_d = (mem_wr || mem_ref) ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= 1'b0;
      slot_wr_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      cart_overrun <= 1'b0;
    end else if (cart_req) begin
      if (slot_valid_q && !slot_free_now) begin
        cart_overrun <= 1'b1;
      end else begin
        slot_valid_q <= 1'b1;
        slot_wr_q    <= cart_wr;
        slot_addr_q  <= cart_addr;
        slot_wdata_q <= cart_wdata;
      end
    end else if (slot_free_now) begin
      slot_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt_q     <= RELOAD;
      ref_pending_q <= 1'b0;
      ref_overrun   <= 1'b0;
    end else begin
      ref_cnt_q <= ref_expire ? RELOAD : ref_cnt_q - 1'b1;
      if (ref_expire) begin
        if (ref_pending_q && !ref_clear) ref_overrun <= 1'b1;
        ref_pending_q <= 1'b1;
      end else if (ref_clear) begin
        ref_pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_ref   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_cart) begin
      mem_valid <= 1'b1;
      mem_wr    <= sel_wr;
      mem_ref   <= 1'b0;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
    end else if (grant_ref) begin
      mem_valid <= 1'b1;
      mem_wr    <= 1'b0;
      mem_ref   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_ld) begin
      mem_valid <= 1'b1;
      mem_wr    <= ld_wr;
      mem_ref   <= 1'b0;
      mem_addr  <= ld_addr;
      mem_wdata <= ld_wdata;
    end else if (accept) begin
      mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cart_ack   <= 1'b0;
      ld_ack     <= 1'b0;
      cart_rdata <= '0;
      ld_rdata   <= '0;
    end else begin
      cart_ack <= (src_q == SRC_CART) && ((accept && mem_wr) || rd_done);
      ld_ack   <= (src_q == SRC_LD) && ((accept && mem_wr) || rd_done);
      if (rd_done && src_q == SRC_CART) cart_rdata <= mem_rdata;
      if (rd_done && src_q == SRC_LD)   ld_rdata   <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter with a 2-cycle-latency memory model.
module tb_cart_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cart_req, cart_wr;
  logic [22:0] cart_addr;
  logic [7:0]  cart_wdata, cart_rdata;
  logic        cart_ack;
  logic        ld_req, ld_wr;
  logic [22:0] ld_addr;
  logic [7:0]  ld_wdata, ld_rdata;
  logic        ld_ack;
  logic        mem_valid, mem_ready, mem_wr, mem_ref;
  logic [22:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        ref_overrun, cart_overrun;

  int checks = 0;
  int failures = 0;
  int cart_ack_cnt = 0;
  int ld_ack_cnt = 0;

  logic        log_ref[$];
  logic        log_wr[$];
  logic [22:0] log_addr[$];
  logic [7:0]  log_wdata[$];

  logic [7:0] mem_arr [0:255] = '{default: 8'h00};
  logic       rd_stage = 1'b0;
  logic [7:0] rd_data_q = '0;

  always #5 clk = ~clk;

  cart_mem_arbiter #(.REFRESH_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cart_req(cart_req), .cart_wr(cart_wr), .cart_addr(cart_addr),
    .cart_wdata(cart_wdata), .cart_rdata(cart_rdata), .cart_ack(cart_ack),
    .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr),
    .mem_ref(mem_ref), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ref_overrun(ref_overrun), .cart_overrun(cart_overrun)
  );

  // Memory model: accepts on valid&ready, returns read data two cycles later.
  always @(posedge clk) begin
    mem_rvalid <= rd_stage;
    mem_rdata  <= rd_data_q;
    rd_stage   <= 1'b0;
    if (mem_valid && mem_ready) begin
      log_ref.push_back(mem_ref);
      log_wr.push_back(mem_wr);
      log_addr.push_back(mem_addr);
      log_wdata.push_back(mem_wdata);
      if (!mem_ref && mem_wr) begin
        mem_arr[mem_addr[7:0]] <= mem_wdata;
      end else if (!mem_ref) begin
        rd_stage  <= 1'b1;
        rd_data_q <= mem_arr[mem_addr[7:0]];
      end
    end
    if (cart_ack) cart_ack_cnt++;
    if (ld_ack)   ld_ack_cnt++;
  end

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0;
    cart_req = 1'b0; cart_wr = 1'b0; cart_addr = '0; cart_wdata = '0;
    ld_req = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_wdata = '0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    log_ref.delete(); log_wr.delete(); log_addr.delete(); log_wdata.delete();
    cart_ack_cnt = 0;
    ld_ack_cnt = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    cart_req = 1'b0; cart_wr = 1'b0; cart_addr = '0; cart_wdata = '0;
    ld_req = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_wdata = '0;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_valid, mem_wr, mem_ref, cart_ack, ld_ack, ref_overrun, cart_overrun,
         mem_addr, mem_wdata, cart_rdata, ld_rdata} !== 0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b wr=%b ref=%b cack=%b lack=%b rov=%b cov=%b addr=%h wd=%h crd=%h lrd=%h expected all 0",
               mem_valid, mem_wr, mem_ref, cart_ack, ld_ack, ref_overrun, cart_overrun,
               mem_addr, mem_wdata, cart_rdata, ld_rdata);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_valid, cart_ack, ld_ack, ref_overrun, cart_overrun} !== 5'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got valid=%b cack=%b lack=%b rov=%b cov=%b expected 0",
               mem_valid, cart_ack, ld_ack, ref_overrun, cart_overrun);
    end
  endtask

  task automatic test_write_read;
    do_reset();
    cart_req = 1'b1; cart_wr = 1'b1; cart_addr = 23'h420005; cart_wdata = 8'hA5;
    @(negedge clk);
    cart_req = 1'b0;
    checks++;
    if ({mem_valid, mem_wr, mem_ref, mem_addr, mem_wdata} !== {3'b110, 23'h420005, 8'hA5}) begin
      failures++;
      $display("FAIL wr_cmd_t1: got valid=%b wr=%b ref=%b addr=%h wd=%h expected 1 1 0 420005 a5",
               mem_valid, mem_wr, mem_ref, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({cart_ack, mem_valid} !== 2'b10) begin
      failures++;
      $display("FAIL wr_ack_t2: got ack=%b valid=%b expected ack=1 valid=0", cart_ack, mem_valid);
    end
    cart_req = 1'b1; cart_wr = 1'b0; cart_addr = 23'h420005; cart_wdata = 8'h00;
    @(negedge clk);
    cart_req = 1'b0;
    checks++;
    if ({mem_valid, mem_wr, mem_addr} !== {2'b10, 23'h420005}) begin
      failures++;
      $display("FAIL rd_cmd_t1: got valid=%b wr=%b addr=%h expected 1 0 420005", mem_valid, mem_wr, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cart_ack !== 1'b0) begin
      failures++;
      $display("FAIL rd_early_ack: got ack=%b at t+3 expected 0", cart_ack);
    end
    @(negedge clk);
    checks++;
    if ({cart_ack, cart_rdata} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL rd_ack_t4: got ack=%b rdata=%h expected ack=1 rdata=a5", cart_ack, cart_rdata);
    end
    @(negedge clk);
    checks++;
    if ({cart_ack, cart_rdata, cart_ack_cnt} !== {1'b0, 8'hA5, 32'd2}) begin
      failures++;
      $display("FAIL rd_ack_pulse: got ack=%b rdata=%h acks=%0d expected ack=0 rdata=a5 acks=2",
               cart_ack, cart_rdata, cart_ack_cnt);
    end
  endtask

  task automatic test_priority;
    bit got_ack = 1'b0;
    do_reset();
    // ref_pending becomes visible after the 16th edge following release.
    repeat (16) @(negedge clk);
    cart_req = 1'b1; cart_wr = 1'b0; cart_addr = 23'h420005;
    ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 23'h420100; ld_wdata = 8'h3C;
    @(negedge clk);
    cart_req = 1'b0;
    for (int i = 0; i < 30 && !got_ack; i++) begin
      @(negedge clk);
      if (ld_ack) begin
        got_ack = 1'b1;
        ld_req = 1'b0;
      end
    end
    checks++;
    if (!got_ack) begin
      failures++;
      $display("FAIL prio_ld_ack_timeout: got no ld_ack in 30 cycles expected one");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (log_ref.size() !== 3) begin
      failures++;
      $display("FAIL prio_cmd_count: got %0d commands expected 3", log_ref.size());
    end else begin
      checks++;
      if ({log_ref[0], log_wr[0], log_addr[0]} !== {2'b00, 23'h420005}) begin
        failures++;
        $display("FAIL prio_first_cart: got ref=%b wr=%b addr=%h expected 0 0 420005",
                 log_ref[0], log_wr[0], log_addr[0]);
      end
      checks++;
      if ({log_ref[1], log_wr[1]} !== 2'b10) begin
        failures++;
        $display("FAIL prio_second_ref: got ref=%b wr=%b expected 1 0", log_ref[1], log_wr[1]);
      end
      checks++;
      if ({log_ref[2], log_wr[2], log_addr[2], log_wdata[2]} !== {2'b01, 23'h420100, 8'h3C}) begin
        failures++;
        $display("FAIL prio_third_ld: got ref=%b wr=%b addr=%h wd=%h expected 0 1 420100 3c",
                 log_ref[2], log_wr[2], log_addr[2], log_wdata[2]);
      end
    end
    checks++;
    if ({ld_ack_cnt, cart_ack_cnt} !== {32'd1, 32'd1}) begin
      failures++;
      $display("FAIL prio_ack_counts: got ld=%0d cart=%0d expected ld=1 cart=1", ld_ack_cnt, cart_ack_cnt);
    end
    checks++;
    if (cart_rdata !== 8'hA5) begin
      failures++;
      $display("FAIL prio_cart_rdata: got %h expected a5", cart_rdata);
    end
  endtask

  task automatic test_stall;
    do_reset();
    mem_ready = 1'b0;
    ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 23'h420200; ld_wdata = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_valid, mem_wr, mem_addr, mem_wdata} !== {2'b11, 23'h420200, 8'h5A}) begin
        failures++;
        $display("FAIL stall_hold_%0d: got valid=%b wr=%b addr=%h wd=%h expected 1 1 420200 5a",
                 i, mem_valid, mem_wr, mem_addr, mem_wdata);
      end
      if (i == 5) mem_ready = 1'b1;
    end
    @(negedge clk);
    checks++;
    if ({ld_ack, mem_valid} !== 2'b10) begin
      failures++;
      $display("FAIL stall_ack: got ack=%b valid=%b expected ack=1 valid=0", ld_ack, mem_valid);
    end
    ld_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ld_ack_cnt, log_addr.size()} !== {32'd1, 32'd1}) begin
      failures++;
      $display("FAIL stall_single: got acks=%0d cmds=%0d expected 1 1", ld_ack_cnt, log_addr.size());
    end
  endtask

  task automatic test_ref_overrun;
    do_reset();
    mem_ready = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (ref_overrun !== 1'b0) begin
      failures++;
      $display("FAIL ref_overrun_early: got %b expected 0", ref_overrun);
    end
    repeat (30) @(negedge clk);
    checks++;
    if ({ref_overrun, mem_valid, mem_ref} !== 3'b111) begin
      failures++;
      $display("FAIL ref_overrun_set: got ov=%b valid=%b ref=%b expected 1 1 1", ref_overrun, mem_valid, mem_ref);
    end
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cart_overrun;
    bit got_ack = 1'b0;
    int n3 = 0;
    do_reset();
    mem_ready = 1'b0;
    ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 23'h420200; ld_wdata = 8'h11;
    @(negedge clk);
    @(negedge clk);
    cart_req = 1'b1; cart_wr = 1'b1; cart_addr = 23'h420300; cart_wdata = 8'h77;
    @(negedge clk);
    cart_req = 1'b0;
    checks++;
    if (cart_overrun !== 1'b0) begin
      failures++;
      $display("FAIL cart_ov_first: got %b expected 0", cart_overrun);
    end
    @(negedge clk);
    cart_req = 1'b1; cart_addr = 23'h420301;
    @(negedge clk);
    cart_req = 1'b0;
    @(negedge clk);
    cart_req = 1'b1; cart_addr = 23'h420302;
    @(negedge clk);
    cart_req = 1'b0;
    checks++;
    if (cart_overrun !== 1'b1) begin
      failures++;
      $display("FAIL cart_ov_set: got %b expected 1", cart_overrun);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && !got_ack; i++) begin
      @(negedge clk);
      if (ld_ack) begin
        got_ack = 1'b1;
        ld_req = 1'b0;
      end
    end
    checks++;
    if (!got_ack) begin
      failures++;
      $display("FAIL cart_ov_ld_timeout: got no ld_ack in 20 cycles expected one");
    end
    repeat (6) @(negedge clk);
    for (int i = 0; i < log_addr.size(); i++) begin
      if (log_addr[i][22:8] == 15'h4203) n3++;
    end
    checks++;
    if ({n3, cart_ack_cnt} !== {32'd1, 32'd1}) begin
      failures++;
      $display("FAIL cart_ov_one_cmd: got cart_cmds=%0d acks=%0d expected 1 1", n3, cart_ack_cnt);
    end
    checks++;
    if (mem_arr[8'h00] !== 8'h77) begin
      failures++;
      $display("FAIL cart_ov_data: got mem[00]=%h expected 77 (from 420300)", mem_arr[8'h00]);
    end
  endtask

  task automatic test_reset_mid_read;
    int saved;
    do_reset();
    cart_req = 1'b1; cart_wr = 1'b0; cart_addr = 23'h420005;
    @(negedge clk);
    cart_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    saved = cart_ack_cnt;
    @(negedge clk);
    checks++;
    if ({mem_valid, mem_wr, mem_ref, cart_ack, ld_ack, ref_overrun, cart_overrun,
         mem_addr, mem_wdata, cart_rdata, ld_rdata} !== 0) begin
      failures++;
      $display("FAIL midrd_reset_outputs: got valid=%b addr=%h crd=%h ack=%b expected all 0",
               mem_valid, mem_addr, cart_rdata, cart_ack);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({cart_ack_cnt - saved, cart_rdata} !== {32'd0, 8'h00}) begin
      failures++;
      $display("FAIL midrd_no_ack: got acks=%0d rdata=%h expected 0 00", cart_ack_cnt - saved, cart_rdata);
    end
    cart_req = 1'b1; cart_wr = 1'b0; cart_addr = 23'h420005;
    @(negedge clk);
    cart_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cart_ack, cart_rdata} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL midrd_fresh_read: got ack=%b rdata=%h expected ack=1 rdata=a5", cart_ack, cart_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    cart_req = 1'b0; cart_wr = 1'b0; cart_addr = '0; cart_wdata = '0;
    ld_req = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_wdata = '0;
    mem_ready = 1'b1;
    test_reset();
    test_write_read();
    test_priority();
    test_stall();
    test_ref_overrun();
    test_cart_overrun();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
